// File: rtl/fx2_slave_fifo_if.sv
// fx2_slave_fifo_if: slave-FIFO bus between the FPGA-side master and the FX2-side responder.
interface fx2_slave_fifo_if;
  logic [1:0]  sl_fifo_adr;
  logic        sl_rd;
  logic        sl_oe;
  logic        sl_wr;
  logic [15:0] sl_wr_data;
  logic        sl_pktend;
  logic [15:0] sl_rd_data;
  logic        flag_a;
  logic        flag_b;
  logic        flag_c;
  logic        flag_d;
  modport master (
    output sl_fifo_adr, sl_rd, sl_oe, sl_wr, sl_wr_data, sl_pktend,
    input  sl_rd_data, flag_a, flag_b, flag_c, flag_d
  );
  modport slave (
    input  sl_fifo_adr, sl_rd, sl_oe, sl_wr, sl_wr_data, sl_pktend,
    output sl_rd_data, flag_a, flag_b, flag_c, flag_d
  );
endinterface

// File: rtl/fx2_slave_fifo_responder.sv
// fx2_slave_fifo_responder: FX2-side slave-FIFO model with host inject/drain ports.
// Define FX2_MODEL_LOOPBACK_EN to route committed EP6/EP8 words back into EP2/EP4.
module fx2_slave_fifo_responder #(
  parameter int DEPTH_LOG2 = 9,
  parameter int PKT_WORDS  = 256
) (
  input  logic            clk,
  input  logic            rst,
  fx2_slave_fifo_if.slave sl,
  input  logic            host_out_valid_i,
  input  logic            host_out_ep_i,
  input  logic [15:0]     host_out_data_i,
  output logic            host_out_ready_o,
  input  logic            host_in_ep_i,
  input  logic            host_in_re_i,
  output logic [15:0]     host_in_data_o,
  output logic            host_in_valid_o,
  output logic [3:0]      err_o,
  output logic [7:0]      zlp_count_o
);
  localparam int AW    = DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [PW-1:0] FULL_DIFF = {1'b1, {AW{1'b0}}};
  localparam logic [PW-1:0] PKT       = PW'(PKT_WORDS);
  // endpoint index equals sl_fifo_adr: 0=EP2, 1=EP4, 2=EP6, 3=EP8
  logic [15:0]   mem_q [4][DEPTH];
  logic [PW-1:0] wp_q [4];
  logic [PW-1:0] wp_d [4];
  logic [PW-1:0] rp_q [4];
  logic [PW-1:0] rp_d [4];
  logic [PW-1:0] cp_q [2];
  logic [PW-1:0] cp_d [2];
  logic [3:0]    empty, full, we;
  logic [15:0]   wdat [4];
  logic [3:0]    flags_q, flags_d, err_q, err_set;
  logic [7:0]    zlp_q, zlp_d;
  logic [1:0]    adr, hout, hin;
  logic          rd_only, wr_only, m_pop, m_push, h_push;
`ifdef FX2_MODEL_LOOPBACK_EN
  logic [1:0]    lb;
`else
  logic          h_pop;
`endif
  assign adr     = sl.sl_fifo_adr;
  assign hout    = {1'b0, host_out_ep_i};
  assign hin     = {1'b1, host_in_ep_i};
  assign rd_only = sl.sl_rd & ~sl.sl_wr;
  assign wr_only = sl.sl_wr & ~sl.sl_rd;
  always_comb begin
    for (int e = 0; e < 4; e++) begin
      empty[e] = wp_q[e] == rp_q[e];
      full[e]  = (wp_q[e] ^ rp_q[e]) == FULL_DIFF;
    end
  end
  assign m_pop            = rd_only & ~adr[1] & ~empty[adr];
  assign m_push           = wr_only & adr[1] & ~full[adr];
  assign host_out_ready_o = ~full[hout];
  assign h_push           = host_out_valid_i & host_out_ready_o;
  assign sl.sl_rd_data    = (sl.sl_oe && !adr[1] && !empty[adr]) ? mem_q[adr][rp_q[adr][AW-1:0]] : '0;
`ifdef FX2_MODEL_LOOPBACK_EN
  assign host_in_valid_o  = 1'b0;
  assign host_in_data_o   = '0;
`else
  assign host_in_valid_o  = cp_q[host_in_ep_i] != rp_q[hin];
  assign host_in_data_o   = host_in_valid_o ? mem_q[hin][rp_q[hin][AW-1:0]] : '0;
  assign h_pop            = host_in_re_i & host_in_valid_o;
`endif
  assign err_set = {sl.sl_rd & sl.sl_wr,
                    (rd_only & adr[1]) | (wr_only & ~adr[1]),
                    wr_only & adr[1] & full[adr],
                    rd_only & ~adr[1] & empty[adr]};
  always_comb begin
    for (int e = 0; e < 4; e++) begin
      wp_d[e] = wp_q[e];
      rp_d[e] = rp_q[e];
      we[e]   = 1'b0;
      wdat[e] = '0;
    end
    cp_d  = cp_q;
    zlp_d = zlp_q;
    if (m_pop) rp_d[adr] = rp_q[adr] + 1'b1;
    if (m_push) begin
      wp_d[adr] = wp_q[adr] + 1'b1;
      we[adr]   = 1'b1;
      wdat[adr] = sl.sl_wr_data;
    end
    if (h_push) begin
      wp_d[hout] = wp_q[hout] + 1'b1;
      we[hout]   = 1'b1;
      wdat[hout] = host_out_data_i;
    end
`ifdef FX2_MODEL_LOOPBACK_EN
    // host pushes win the OUT write port; loopback retries next cycle
    for (int k = 0; k < 2; k++) begin
      lb[k] = (cp_q[k] != rp_q[k+2]) && !full[k] && !(h_push && hout == 2'(k));
      if (lb[k]) begin
        rp_d[k+2] = rp_q[k+2] + 1'b1;
        wp_d[k]   = wp_q[k] + 1'b1;
        we[k]     = 1'b1;
        wdat[k]   = mem_q[k+2][rp_q[k+2][AW-1:0]];
      end
    end
`else
    if (h_pop) rp_d[hin] = rp_q[hin] + 1'b1;
`endif
    for (int k = 0; k < 2; k++) begin
      if (sl.sl_pktend && adr == 2'(k + 2)) begin
        cp_d[k] = wp_d[k+2];
        if (wp_q[k+2] == cp_q[k] && !m_push) zlp_d = zlp_q + 8'd1;
      end else if (wp_d[k+2] - cp_q[k] == PKT) begin
        cp_d[k] = wp_d[k+2];
      end
    end
    flags_d = {(wp_d[2] ^ rp_d[2]) == FULL_DIFF, (wp_d[3] ^ rp_d[3]) == FULL_DIFF,
               wp_d[0] == rp_d[0], wp_d[1] == rp_d[1]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < 4; e++) begin
        wp_q[e] <= '0;
        rp_q[e] <= '0;
      end
      cp_q[0] <= '0;
      cp_q[1] <= '0;
      flags_q <= 4'b0011;
      err_q   <= '0;
      zlp_q   <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cp_q    <= cp_d;
      flags_q <= flags_d;
      err_q   <= err_q | err_set;
      zlp_q   <= zlp_d;
    end
  end
  always_ff @(posedge clk) begin
    for (int e = 0; e < 4; e++)
      if (we[e]) mem_q[e][wp_q[e][AW-1:0]] <= wdat[e];
  end
  assign sl.flag_a   = flags_q[0];
  assign sl.flag_b   = flags_q[1];
  assign sl.flag_c   = flags_q[2];
  assign sl.flag_d   = flags_q[3];
  assign err_o       = err_q;
  assign zlp_count_o = zlp_q;
endmodule

// File: doc/fx2_slave_fifo_responder.md
Name: fx2_slave_fifo_responder

Overview:
Synthesizable model of the FX2 side of the slave-FIFO protocol. It responds to the FPGA-side master strobes (sl_rd, sl_wr, sl_oe, sl_pktend, sl_fifo_adr) and drives the four endpoint flags and the read data. It is used for on-chip and simulation loopback of usb_slave_fifo_interface without a PC attached. A host-side port injects OUT words into EP2/EP4 and drains committed IN packets from EP6/EP8.

Parameters:
DEPTH_LOG2, 9, log2 of words per endpoint buffer (512 words)
PKT_WORDS, 256, words per full IN packet (512-byte high-speed packet); must be <= 2**DEPTH_LOG2

Ports:
clk  input  1  single clock (usb_locked_ifclk_in domain)
rst  input  1  synchronous reset, active-high
sl_fifo_adr  input  2  00=EP2 (OUT data), 01=EP4 (OUT cs), 10=EP6 (IN data), 11=EP8 (IN cs)
sl_rd  input  1  pop strobe, active-high
sl_oe  input  1  read-data enable, active-high
sl_wr  input  1  push strobe, active-high
sl_wr_data  input  16  word written by master
sl_pktend  input  1  commit partial IN packet, active-high
sl_rd_data  output  16  head word of selected OUT endpoint
flag_a  output  1  EP4 empty
flag_b  output  1  EP2 empty
flag_c  output  1  EP8 full
flag_d  output  1  EP6 full
host_out_valid  input  1  host push into OUT endpoint
host_out_ep  input  1  0=EP2, 1=EP4
host_out_data  input  16  host word
host_out_ready  output  1  selected OUT endpoint not full
host_in_ep  input  1  0=EP6, 1=EP8
host_in_re  input  1  host pop of committed IN word
host_in_data  output  16  head committed word of selected IN endpoint
host_in_valid  output  1  selected IN endpoint has >=1 committed word
err  output  4  sticky: [0] underrun, [1] overrun, [2] direction error, [3] rd+wr same cycle
zlp_count  output  8  zero-length packets committed, wraps at 255

Behaviour:
- All flags and host-side signals are active-high, post-IO-buffer polarity.
- Each endpoint is a circular buffer with DEPTH_LOG2+1-bit read/write pointers; IN endpoints also keep a commit pointer.
- Reset: all pointers 0; flag_a=1, flag_b=1, flag_c=0, flag_d=0; sl_rd_data=0; host_out_ready=1; host_in_valid=0; host_in_data=0; err=0; zlp_count=0.
- Flags are registered. Each flag reflects the state after the previous edge, giving one cycle of latency as on the real FX2. The master must tolerate one stale cycle; violations are caught through err.
- sl_rd_data: combinational head of EP2/EP4 per sl_fifo_adr when sl_oe=1; 0 when sl_oe=0 or an IN address is selected.
- sl_rd=1, OUT address, not empty: pop one word per cycle. If empty: no pop, set err[0].
- sl_wr=1, IN address, not full: push sl_wr_data as an uncommitted word. If full (committed plus uncommitted == depth): drop the word and set err[1].
- sl_rd to an IN address, or sl_wr to an OUT address: ignored, set err[2].
- sl_rd and sl_wr in the same cycle: both ignored, set err[3].
- Commit: when the uncommitted count reaches PKT_WORDS, the commit pointer advances on that edge.
- sl_pktend=1 with an IN address: commit all uncommitted words. If a word is being written on the same cycle, that word is included. If nothing is uncommitted and no word is being written, zlp_count increments.
- Host OUT push: a word is accepted when host_out_valid && host_out_ready. A host push and an sl_rd pop on the same endpoint in the same cycle both take effect, and the count is unchanged.
- Host IN pop: host_in_re && host_in_valid pops one committed word. Popping while host_in_valid=0 is ignored.
- host_in_valid and host_in_data are combinational from the commit and read pointers.
- Pointer wrap: natural modulo 2**(DEPTH_LOG2+1). full = MSBs differ and low bits are equal.
- Asserting rst mid-packet discards all buffered and uncommitted data on the next edge.

Optional Feature:
FX2_MODEL_LOOPBACK_EN:
- Defined: committed EP6 words auto-transfer to EP2 and committed EP8 words to EP4. One word per endpoint pair per cycle, only when the destination is not full. host_in_valid is forced to 0, host_in_re is ignored, and host_out_* keeps priority over loopback on the same cycle.
- Undefined: no loopback path; the host ports behave as specified above.

Test Plan:
- Reset, then host pushes 0x0001..0x0004 into EP2 → flag_b falls the cycle after the first push. Master reads EP2 with sl_oe=1 and sl_rd for 4 cycles → sl_rd_data 0x0001..0x0004; flag_b=1 one cycle after the last pop; err=0.
- Master writes 256 words (0xA000+i) to EP6 → host_in_valid rises the cycle after the 256th word; host drains exactly 256 words in order.
- Master writes 3 words to EP8, then pulses sl_pktend → host_in_valid=1 with 3 words. A second sl_pktend with no writes → zlp_count=1.
- Fill EP6 with 512 words without host reads → flag_d=1 one cycle later. A 513th sl_wr → word dropped, err[1]=1.
- sl_rd on empty EP4 → err[0]=1. sl_wr with fifo_adr=00 → err[2]=1. sl_rd and sl_wr together → err[3]=1, no pointer change.
- With FX2_MODEL_LOOPBACK_EN: write 5 words to EP6 plus sl_pktend → within 6 cycles flag_b=0, and reading EP2 returns the same 5 words in order.
